inst_fetch_ras: RTL and testbench

Parametrised program counter and instruction-fetch sequencer for the CSE141L-style processor. It supports:
- absolute and relative conditional branches;
- hardware call/return through an internal return-address stack (RAS);
- stall, halt, and per-program start vectors.

It sits between the control decoder/ALU flags and the instruction ROM address port, and replaces the single-mode PC.

---
 rtl/inst_fetch_ras.sv | 157 +++++++++++++++
 tb/tb_inst_fetch_ras.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ras.sv
// Program counter / fetch sequencer with absolute+relative branches and a call/return stack.
// Latency: every action lands on ProgCtr at the next Clk edge; no input-to-ProgCtr comb path.
// Backpressure: Stall freezes PC, stack and state for the cycle; the decoder re-presents the request.
//
// Ports:
//   Clk, Reset            clock and synchronous active-high reset
//   Start, StartAddr      load-and-hold the start vector (state LOAD), released into RUN
//   Stall, Halt           freeze for one cycle / stop into HALTED
//   BranchAbs, BranchRel  conditional branches qualified by ALU_flag
//   Call, Ret             push PC+1 and jump / pop and jump via the return-address stack
//   Target                absolute target or signed offset (BranchRel)
//   ProgCtr               registered program counter (instruction ROM address)
//   Running, Done         registered decodes of RUN / HALTED
//   StackDepth, StackErr  valid stack entries / sticky overflow-underflow flag
module inst_fetch_ras #(
    parameter int T = 10,
    parameter int D = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Start,
    input  logic [T-1:0]           StartAddr,
    input  logic                   Stall,
    input  logic                   Halt,
    input  logic                   BranchAbs,
    input  logic                   BranchRel,
    input  logic                   Call,
    input  logic                   Ret,
    input  logic                   ALU_flag,
    input  logic [T-1:0]           Target,
    output logic [T-1:0]           ProgCtr,
    output logic                   Running,
    output logic                   Done,
    output logic [$clog2(D+1)-1:0] StackDepth,
    output logic                   StackErr
);

    localparam int DW = $clog2(D + 1);
    localparam logic [DW-1:0] DEPTH_ONE = DW'(1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(D);
    localparam logic [T-1:0]  PC_ONE    = T'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [T-1:0]    pc_nxt;
    logic [DW-1:0]   depth_nxt;
    logic            err_nxt;
    logic            push;
    logic [T-1:0]    pc_inc;
    logic [T-1:0]    top;
    logic [T-1:0]    stack [D];

    // Increment wraps naturally mod 2^T; this is also the return address.
    assign pc_inc = ProgCtr + PC_ONE;

    // Top-of-stack select written as a compare loop so the index width
    // never has to match the array bound exactly.
    always_comb begin
        top = '0;
        for (int i = 0; i < D; i++) begin
            if (DW'(i) == (StackDepth - DEPTH_ONE)) begin
                top = stack[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = ProgCtr;
        depth_nxt = StackDepth;
        err_nxt   = StackErr;
        push      = 1'b0;

        if (Start) begin
            // Start overrides everything except Reset, including Stall.
            state_nxt = LOAD;
            pc_nxt    = StartAddr;
            depth_nxt = '0;
            err_nxt   = 1'b0;
        end else begin
            unique case (state)
                IDLE:   ;
                LOAD:   state_nxt = RUN;
                RUN: begin
                    if (!Stall) begin
                        if (Halt) begin
                            state_nxt = HALTED;
                        end else if (Ret) begin
                            if (StackDepth != '0) begin
                                pc_nxt    = top;
                                depth_nxt = StackDepth - DEPTH_ONE;
                            end else begin
                                err_nxt   = 1'b1;
                                state_nxt = HALTED;
                            end
                        end else if (Call) begin
                            if (StackDepth != DEPTH_MAX) begin
                                push      = 1'b1;
                                pc_nxt    = Target;
                                depth_nxt = StackDepth + DEPTH_ONE;
                            end else begin
                                err_nxt   = 1'b1;
                                state_nxt = HALTED;
                            end
                        end else if (BranchAbs && ALU_flag) begin
                            pc_nxt = Target;
                        end else if (BranchRel && ALU_flag) begin
                            // Two's-complement offset: plain T-bit add gives the signed result mod 2^T.
                            pc_nxt = ProgCtr + Target;
                        end else begin
                            pc_nxt = pc_inc;
                        end
                    end
                end
                HALTED: ;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            ProgCtr    <= '0;
            StackDepth <= '0;
            StackErr   <= 1'b0;
            Running    <= 1'b0;
            Done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            ProgCtr    <= pc_nxt;
            StackDepth <= depth_nxt;
            StackErr   <= err_nxt;
            // Decoded from the next state so the flags track the state register exactly.
            Running    <= (state_nxt == RUN);
            Done       <= (state_nxt == HALTED);
        end
    end

    // Stack storage needs no reset: entries at or above StackDepth are never read.
    always_ff @(posedge Clk) begin
        if (push) begin
            for (int i = 0; i < D; i++) begin
                if (DW'(i) == StackDepth) begin
                    stack[i] <= pc_inc;
                end
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_ras.sv
module tb_inst_fetch_ras;

    localparam int T  = 10;
    localparam int D  = 4;
    localparam int DW = $clog2(D + 1);

    // Control mask bit positions.
    localparam logic [8:0] C_RST   = 9'h100;
    localparam logic [8:0] C_START = 9'h080;
    localparam logic [8:0] C_STALL = 9'h040;
    localparam logic [8:0] C_HALT  = 9'h020;
    localparam logic [8:0] C_BABS  = 9'h010;
    localparam logic [8:0] C_BREL  = 9'h008;
    localparam logic [8:0] C_CALL  = 9'h004;
    localparam logic [8:0] C_RET   = 9'h002;
    localparam logic [8:0] C_FLAG  = 9'h001;
    localparam logic [8:0] C_NONE  = 9'h000;

    logic          Clk;
    logic          Reset, Start, Stall, Halt, BranchAbs, BranchRel, Call, Ret, ALU_flag;
    logic [T-1:0]  StartAddr, Target, ProgCtr;
    logic          Running, Done, StackErr;
    logic [DW-1:0] StackDepth;

    int n_tests = 0;
    int n_fail  = 0;

    inst_fetch_ras #(.T(T), .D(D)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Stall(Stall), .Halt(Halt), .BranchAbs(BranchAbs), .BranchRel(BranchRel),
        .Call(Call), .Ret(Ret), .ALU_flag(ALU_flag), .Target(Target),
        .ProgCtr(ProgCtr), .Running(Running), .Done(Done),
        .StackDepth(StackDepth), .StackErr(StackErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        string        name;
        logic [8:0]   ctl;
        logic [T-1:0] addr;   // drives both StartAddr and Target
        logic [T-1:0] pc;
        logic         run;
        logic         done;
        logic [DW-1:0] depth;
        logic         err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [8:0] ctl, logic [T-1:0] addr,
                                logic [T-1:0] pc, logic run, logic done,
                                logic [DW-1:0] depth, logic err);
        vec_t v;
        v.name = name; v.ctl = ctl; v.addr = addr; v.pc = pc;
        v.run = run; v.done = done; v.depth = depth; v.err = err;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(logic [8:0] ctl, logic [T-1:0] addr);
        Reset     = ctl[8];
        Start     = ctl[7];
        Stall     = ctl[6];
        Halt      = ctl[5];
        BranchAbs = ctl[4];
        BranchRel = ctl[3];
        Call      = ctl[2];
        Ret       = ctl[1];
        ALU_flag  = ctl[0];
        StartAddr = addr;
        Target    = addr;
    endtask

    // Drive, take one edge, sample 1 time unit after it.
    task automatic step(logic [8:0] ctl, logic [T-1:0] addr);
        drive(ctl, addr);
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all(vec_t v);
        check({v.name, ".pc"},    32'(ProgCtr),    32'(v.pc));
        check({v.name, ".run"},   32'(Running),    32'(v.run));
        check({v.name, ".done"},  32'(Done),       32'(v.done));
        check({v.name, ".depth"}, 32'(StackDepth), 32'(v.depth));
        check({v.name, ".err"},   32'(StackErr),   32'(v.err));
    endtask

    logic [T-1:0] m_pc;
    logic [T-1:0] m_stack[$];

    initial begin
        drive(C_NONE, '0);

        //                   name          ctl                       addr    pc     run done dep err
        vecs.push_back(mk("reset",      C_RST,                    10'h000, 10'h000, 0, 0, 0, 0));
        vecs.push_back(mk("idle",       C_NONE,                   10'h000, 10'h000, 0, 0, 0, 0));
        vecs.push_back(mk("start1",     C_START,                  10'h040, 10'h040, 0, 0, 0, 0));
        vecs.push_back(mk("start2",     C_START,                  10'h040, 10'h040, 0, 0, 0, 0));
        vecs.push_back(mk("start3",     C_START,                  10'h040, 10'h040, 0, 0, 0, 0));
        vecs.push_back(mk("run0",       C_NONE,                   10'h000, 10'h040, 1, 0, 0, 0));
        vecs.push_back(mk("run1",       C_NONE,                   10'h000, 10'h041, 1, 0, 0, 0));
        vecs.push_back(mk("run2",       C_NONE,                   10'h000, 10'h042, 1, 0, 0, 0));
        vecs.push_back(mk("babs_050",   C_BABS|C_FLAG,            10'h050, 10'h050, 1, 0, 0, 0));
        vecs.push_back(mk("babs_nf",    C_BABS,                   10'h123, 10'h051, 1, 0, 0, 0));
        vecs.push_back(mk("babs_f",     C_BABS|C_FLAG,            10'h123, 10'h123, 1, 0, 0, 0));
        vecs.push_back(mk("brel_m2",    C_BREL|C_FLAG,            10'h3FE, 10'h121, 1, 0, 0, 0));
        vecs.push_back(mk("brel_nf",    C_BREL,                   10'h3FE, 10'h122, 1, 0, 0, 0));
        vecs.push_back(mk("brel_p5",    C_BREL|C_FLAG,            10'h005, 10'h127, 1, 0, 0, 0));
        vecs.push_back(mk("to_010",     C_BABS|C_FLAG,            10'h010, 10'h010, 1, 0, 0, 0));
        vecs.push_back(mk("call_200",   C_CALL,                   10'h200, 10'h200, 1, 0, 1, 0));
        vecs.push_back(mk("seq_201",    C_NONE,                   10'h000, 10'h201, 1, 0, 1, 0));
        vecs.push_back(mk("call_300",   C_CALL,                   10'h300, 10'h300, 1, 0, 2, 0));
        vecs.push_back(mk("ret1",       C_RET,                    10'h000, 10'h202, 1, 0, 1, 0));
        vecs.push_back(mk("ret2",       C_RET,                    10'h000, 10'h011, 1, 0, 0, 0));
        vecs.push_back(mk("call_b",     C_CALL,                   10'h200, 10'h200, 1, 0, 1, 0));
        vecs.push_back(mk("stall1",     C_STALL|C_CALL|C_RET,     10'h300, 10'h200, 1, 0, 1, 0));
        vecs.push_back(mk("stall2",     C_STALL|C_CALL|C_RET,     10'h300, 10'h200, 1, 0, 1, 0));
        vecs.push_back(mk("ret_over_call", C_CALL|C_RET,          10'h300, 10'h012, 1, 0, 0, 0));
        vecs.push_back(mk("to_3ff",     C_BABS|C_FLAG,            10'h3FF, 10'h3FF, 1, 0, 0, 0));
        vecs.push_back(mk("wrap",       C_NONE,                   10'h000, 10'h000, 1, 0, 0, 0));
        vecs.push_back(mk("to_3ff_b",   C_BABS|C_FLAG,            10'h3FF, 10'h3FF, 1, 0, 0, 0));
        vecs.push_back(mk("call_wrap",  C_CALL,                   10'h100, 10'h100, 1, 0, 1, 0));
        vecs.push_back(mk("ret_wrap",   C_RET,                    10'h000, 10'h000, 1, 0, 0, 0));
        vecs.push_back(mk("call_050",   C_CALL,                   10'h050, 10'h050, 1, 0, 1, 0));
        vecs.push_back(mk("halt_call",  C_HALT|C_CALL,            10'h060, 10'h050, 0, 1, 1, 0));
        vecs.push_back(mk("halted_hold", C_CALL|C_BABS|C_FLAG,    10'h070, 10'h050, 0, 1, 1, 0));
        vecs.push_back(mk("restart",    C_START,                  10'h020, 10'h020, 0, 0, 0, 0));
        vecs.push_back(mk("restart_run", C_NONE,                  10'h000, 10'h020, 1, 0, 0, 0));
        vecs.push_back(mk("ovf_c1",     C_CALL,                   10'h100, 10'h100, 1, 0, 1, 0));
        vecs.push_back(mk("ovf_c2",     C_CALL,                   10'h101, 10'h101, 1, 0, 2, 0));
        vecs.push_back(mk("ovf_c3",     C_CALL,                   10'h102, 10'h102, 1, 0, 3, 0));
        vecs.push_back(mk("ovf_c4",     C_CALL,                   10'h103, 10'h103, 1, 0, 4, 0));
        vecs.push_back(mk("ovf_c5",     C_CALL,                   10'h104, 10'h103, 0, 1, 4, 1));
        vecs.push_back(mk("ovf_frozen", C_NONE,                   10'h000, 10'h103, 0, 1, 4, 1));
        vecs.push_back(mk("ovf_ret_ign", C_RET,                   10'h000, 10'h103, 0, 1, 4, 1));
        vecs.push_back(mk("clr_start",  C_START,                  10'h030, 10'h030, 0, 0, 0, 0));
        vecs.push_back(mk("clr_run",    C_NONE,                   10'h000, 10'h030, 1, 0, 0, 0));
        vecs.push_back(mk("underflow",  C_RET,                    10'h000, 10'h030, 0, 1, 0, 1));
        vecs.push_back(mk("uf_start",   C_START,                  10'h000, 10'h000, 0, 0, 0, 0));
        vecs.push_back(mk("uf_run",     C_NONE,                   10'h000, 10'h000, 1, 0, 0, 0));
        vecs.push_back(mk("rst_c1",     C_CALL,                   10'h200, 10'h200, 1, 0, 1, 0));
        vecs.push_back(mk("rst_c2",     C_CALL,                   10'h210, 10'h210, 1, 0, 2, 0));
        vecs.push_back(mk("mid_reset",  C_RST|C_CALL,             10'h220, 10'h000, 0, 0, 0, 0));
        vecs.push_back(mk("post_reset", C_NONE,                   10'h000, 10'h000, 0, 0, 0, 0));
        vecs.push_back(mk("st_3ff",     C_START,                  10'h3FF, 10'h3FF, 0, 0, 0, 0));
        vecs.push_back(mk("st_3ff_run", C_NONE,                   10'h000, 10'h3FF, 1, 0, 0, 0));
        vecs.push_back(mk("call_080",   C_CALL,                   10'h080, 10'h080, 1, 0, 1, 0));
        vecs.push_back(mk("start_in_run", C_START|C_STALL|C_CALL, 10'h040, 10'h040, 0, 0, 0, 0));
        vecs.push_back(mk("start_in_run2", C_NONE,                10'h000, 10'h040, 1, 0, 0, 0));

        // Align input changes away from the active edge.
        @(negedge Clk);
        foreach (vecs[i]) begin
            step(vecs[i].ctl, vecs[i].addr);
            check_all(vecs[i]);
        end

        // LIFO fill-and-unwind against a small reference stack.
        m_pc = 10'h040;
        m_stack.delete();
        for (int k = 0; k < D; k++) begin
            logic [T-1:0] tgt;
            tgt = T'(10'h180 + k * 10'h011);
            m_stack.push_back(m_pc + 10'h001);
            m_pc = tgt;
            step(C_CALL, tgt);
            check($sformatf("lifo_call%0d.pc", k), 32'(ProgCtr), 32'(m_pc));
            check($sformatf("lifo_call%0d.depth", k), 32'(StackDepth), 32'(m_stack.size()));
        end
        for (int k = 0; k < D; k++) begin
            m_pc = m_stack.pop_back();
            step(C_RET, '0);
            check($sformatf("lifo_ret%0d.pc", k), 32'(ProgCtr), 32'(m_pc));
            check($sformatf("lifo_ret%0d.depth", k), 32'(StackDepth), 32'(m_stack.size()));
        end
        check("lifo_end.err", 32'(StackErr), 32'(0));
        check("lifo_end.run", 32'(Running), 32'(1));

        drive(C_NONE, '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
